ldpc_sparse_mult_circulant: RTL and testbench

LDPC_SPARSE_MULT_CIRCULANT -- requirements
Module: ldpc_sparse_mult_circulant

---
 rtl/ldpc_sparse_mult_circulant.sv | 113 +++++++++++
 tb/tb_ldpc_sparse_mult_circulant.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_sparse_mult_circulant.sv
// ldpc_sparse_mult_circulant: ping-pong banked quasi-cyclic sparse matrix x vector product.
// Define LDPC_SPARSE_MULT_LAST_EN to add the o_output_last end-of-block marker.
module ldpc_sparse_mult_circulant #(
    parameter int WIDTH     = 96,
    parameter int IN_WORDS  = 1,
    parameter int OUT_WORDS = 11,
    parameter logic [OUT_WORDS*IN_WORDS*($clog2(WIDTH)+1)-1:0] SHIFT_TABLE =
        (OUT_WORDS*IN_WORDS*($clog2(WIDTH)+1))'(48'h8000_0000_0087)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_input_data,
    input  logic             i_input_valid,
    output logic             o_input_ready,
    output logic [WIDTH-1:0] o_output_data,
    output logic             o_output_valid,
`ifdef LDPC_SPARSE_MULT_LAST_EN
    output logic             o_output_last,
`endif
    input  logic             i_output_ready
);
    localparam int SW = $clog2(WIDTH) + 1;
    localparam int IW = IN_WORDS > 1 ? $clog2(IN_WORDS) : 1;
    localparam int OW = OUT_WORDS > 1 ? $clog2(OUT_WORDS) : 1;
    localparam logic [1:0] FILL_A = 2'd0, FILL_B = 2'd1, WAIT_A = 2'd2, WAIT_B = 2'd3;
    localparam logic [1:0] RD_WAIT_A = 2'd0, RD_A = 2'd1, RD_WAIT_B = 2'd2, RD_B = 2'd3;

    logic [IN_WORDS-1:0][WIDTH-1:0] bank_a_q, bank_b_q;
    logic             full_a_q, full_b_q, full_a_d, full_b_d, run_q;
    logic [1:0]       fill_q, fill_d, rd_q, rd_d;
    logic [IW-1:0]    in_cnt_q, in_cnt_d;
    logic [OW-1:0]    out_cnt_q, out_cnt_d;
    logic             in_fire, out_fire, in_last, out_last;
    logic             set_a, set_b, clr_a, clr_b;
    logic [SW-1:0]    ent;
    logic [WIDTH-1:0] prod;

    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int s);
        int r;
        r = s % WIDTH;
        return r == 0 ? x : (x << r) | (x >> (WIDTH - r));
    endfunction

    assign in_last        = in_cnt_q == IW'(IN_WORDS - 1);
    assign out_last       = out_cnt_q == OW'(OUT_WORDS - 1);
    assign o_input_ready  = run_q & (fill_q == FILL_A ? !full_a_q : fill_q == FILL_B ? !full_b_q : 1'b0);
    assign o_output_valid = rd_q == RD_A || rd_q == RD_B;
    assign in_fire        = i_input_valid & o_input_ready;
    assign out_fire       = o_output_valid & i_output_ready;
    assign set_a          = in_fire & in_last & (fill_q == FILL_A);
    assign set_b          = in_fire & in_last & (fill_q == FILL_B);
    assign clr_a          = out_fire & out_last & (rd_q == RD_A);
    assign clr_b          = out_fire & out_last & (rd_q == RD_B);
    assign full_a_d       = set_a | (full_a_q & !clr_a);
    assign full_b_d       = set_b | (full_b_q & !clr_b);
    assign in_cnt_d       = !in_fire ? in_cnt_q : in_last ? '0 : in_cnt_q + 1'b1;
    assign out_cnt_d      = !out_fire ? out_cnt_q : out_last ? '0 : out_cnt_q + 1'b1;

    // Decisions use next-cycle full flags so a fill and a drain on the same edge never stall.
    always_comb begin
        fill_d = set_a ? (full_b_d ? WAIT_B : FILL_B)
               : set_b ? (full_a_d ? WAIT_A : FILL_A)
               : (fill_q == WAIT_A && !full_a_d) ? FILL_A
               : (fill_q == WAIT_B && !full_b_d) ? FILL_B : fill_q;
        rd_d   = clr_a ? (full_b_d ? RD_B : RD_WAIT_B)
               : clr_b ? (full_a_d ? RD_A : RD_WAIT_A)
               : (rd_q == RD_WAIT_A && full_a_d) ? RD_A
               : (rd_q == RD_WAIT_B && full_b_d) ? RD_B : rd_q;
    end

    always_comb begin
        prod = '0;
        ent  = '0;
        for (int k = 0; k < IN_WORDS; k++) begin
            ent = SHIFT_TABLE[(int'(out_cnt_q) * IN_WORDS + k) * SW +: SW];
            if (ent[SW-1])
                prod ^= rotl(rd_q == RD_B ? bank_b_q[k] : bank_a_q[k], int'(ent[SW-2:0]));
        end
    end

    assign o_output_data = o_output_valid ? prod : '0;
`ifdef LDPC_SPARSE_MULT_LAST_EN
    assign o_output_last = o_output_valid & out_last;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            bank_a_q  <= '0;
            bank_b_q  <= '0;
            full_a_q  <= 1'b0;
            full_b_q  <= 1'b0;
            run_q     <= 1'b0;
            fill_q    <= FILL_A;
            rd_q      <= RD_WAIT_A;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            full_a_q  <= full_a_d;
            full_b_q  <= full_b_d;
            run_q     <= 1'b1;
            fill_q    <= fill_d;
            rd_q      <= rd_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            for (int k = 0; k < IN_WORDS; k++) begin
                if (in_fire && in_cnt_q == IW'(k)) begin
                    if (fill_q == FILL_A) bank_a_q[k] <= i_input_data;
                    else bank_b_q[k] <= i_input_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_ldpc_sparse_mult_circulant.sv
// tb_ldpc_sparse_mult_circulant: directed checks of the default build and a 2-in/3-out variant.
module tb_ldpc_sparse_mult_circulant;
    localparam int W = 96;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    int n_vec = 0, n_err = 0;

    logic d_rst_n, d_in_valid, d_in_ready, d_out_valid, d_out_ready;
    logic [W-1:0] d_in_data, d_out_data;
    logic t_rst_n, t_in_valid, t_in_ready, t_out_valid, t_out_ready;
    logic [W-1:0] t_in_data, t_out_data;
`ifdef LDPC_SPARSE_MULT_LAST_EN
    logic d_last, t_last;
`endif

    ldpc_sparse_mult_circulant u_dflt (
        .i_clock(clk), .i_reset_n(d_rst_n),
        .i_input_data(d_in_data), .i_input_valid(d_in_valid), .o_input_ready(d_in_ready),
        .o_output_data(d_out_data), .o_output_valid(d_out_valid),
`ifdef LDPC_SPARSE_MULT_LAST_EN
        .o_output_last(d_last),
`endif
        .i_output_ready(d_out_ready)
    );

    ldpc_sparse_mult_circulant #(.WIDTH(96), .IN_WORDS(2), .OUT_WORDS(3), .SHIFT_TABLE(48'h8081)) u_two (
        .i_clock(clk), .i_reset_n(t_rst_n),
        .i_input_data(t_in_data), .i_input_valid(t_in_valid), .o_input_ready(t_in_ready),
        .o_output_data(t_out_data), .o_output_valid(t_out_valid),
`ifdef LDPC_SPARSE_MULT_LAST_EN
        .o_output_last(t_last),
`endif
        .i_output_ready(t_out_ready)
    );

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int s);
        return s == 0 ? x : (x << s) | (x >> (W - s));
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic d_push(input logic [W-1:0] x);
        int t = 0;
        d_in_data  = x;
        d_in_valid = 1'b1;
        while (!d_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("d_push_ready", d_in_ready, 1);
        @(negedge clk);
        d_in_valid = 1'b0;
        d_in_data  = '0;
    endtask

    task automatic t_push(input logic [W-1:0] x);
        int t = 0;
        t_in_data  = x;
        t_in_valid = 1'b1;
        while (!t_in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("t_push_ready", t_in_ready, 1);
        @(negedge clk);
        t_in_valid = 1'b0;
        t_in_data  = '0;
    endtask

    task automatic d_drain(input logic [W-1:0] e0, input logic [W-1:0] e5, input string tag);
        for (int b = 0; b < 11; b++) begin
            chk($sformatf("%s_valid%0d", tag, b), d_out_valid, 1);
            chk($sformatf("%s_beat%0d", tag, b), d_out_data, b == 0 ? e0 : b == 5 ? e5 : '0);
`ifdef LDPC_SPARSE_MULT_LAST_EN
            chk($sformatf("%s_last%0d", tag, b), d_last, b == 10);
`endif
            @(negedge clk);
        end
        chk({tag, "_idle_valid"}, d_out_valid, 0);
        chk({tag, "_idle_data"}, d_out_data, 0);
    endtask

    logic [W-1:0] blk [4];
    logic [W-1:0] q [$];
    logic [W-1:0] hold_val;

    initial begin
        int beat, got, cyc, in_idx;
        bit held, sim;
        d_rst_n = 0; t_rst_n = 0;
        d_in_valid = 0; d_in_data = '0; d_out_ready = 1;
        t_in_valid = 0; t_in_data = '0; t_out_ready = 0;
        #12;
        chk("rst_in_ready", d_in_ready, 0);
        chk("rst_out_valid", d_out_valid, 0);
        chk("rst_out_data", d_out_data, 0);
        @(negedge clk);
        d_rst_n = 1; t_rst_n = 1;
        #1 chk("rdy_before_clk", d_in_ready, 0);
        @(negedge clk);
        chk("rdy_first_clk", d_in_ready, 1);

        d_push(96'h1);
        d_drain(96'h80, 96'h1, "r28");
        d_push(96'h8000_0000_0000_0000_0000_0000);
        d_drain(96'h40, 96'h8000_0000_0000_0000_0000_0000, "r29");

        // back-to-back blocks, ready toggling, each new block lands on the previous block's last beat
        blk[0] = 96'h0123_4567_89ab_cdef_fedc_ba98;
        blk[1] = 96'h8000_0000_0000_0000_0000_0001;
        blk[2] = 96'hffff_0000_ffff_0000_ffff_0000;
        blk[3] = 96'h1;
        beat = 0; got = 0; cyc = 0; in_idx = 0; held = 0; sim = 0;
        d_out_ready = 0;
        while (got < 44 && cyc < 2000) begin
            d_out_ready = ~d_out_ready;
            if (sim) begin
                chk("nostall_valid", d_out_valid, 1);
                chk("nostall_ready", d_in_ready, 1);
            end
            if (held) chk("hold_data", d_out_data, hold_val);
            if (!d_out_valid) chk("idle_data_zero", d_out_data, 0);
            sim = 0; held = 0;
            d_in_valid = in_idx < 4 && (!d_out_valid || (beat == 10 && d_out_ready));
            d_in_data  = in_idx < 4 ? blk[in_idx] : '0;
            if (d_in_valid && d_in_ready) begin
                for (int b = 0; b < 11; b++) q.push_back(b == 0 ? rotl(blk[in_idx], 7) : b == 5 ? blk[in_idx] : '0);
                sim = d_out_valid && d_out_ready && beat == 10;
                in_idx++;
            end
            if (d_out_valid && d_out_ready) begin
                if (q.size() == 0) chk("seq_extra_beat", d_out_data, '1);
                else chk($sformatf("seq_beat%0d", got), d_out_data, q.pop_front());
`ifdef LDPC_SPARSE_MULT_LAST_EN
                chk("seq_last", d_last, beat == 10);
`endif
                beat = beat == 10 ? 0 : beat + 1;
                got++;
            end else if (d_out_valid) begin
                held = 1;
                hold_val = d_out_data;
            end
            @(negedge clk);
            cyc++;
        end
        d_in_valid = 0; d_in_data = '0; d_out_ready = 1;
        chk("seq_beats", W'(got), 44);
        chk("seq_blocks", W'(in_idx), 4);

        // reset mid-readout at beat 4
        d_push(96'h1);
        for (int b = 0; b < 4; b++) begin
            chk($sformatf("r32_pre%0d", b), d_out_data, b == 0 ? 96'h80 : '0);
            @(negedge clk);
        end
        chk("r32_beat4_valid", d_out_valid, 1);
        #2 d_rst_n = 0;
        #1;
        chk("r32_rst_valid", d_out_valid, 0);
        chk("r32_rst_data", d_out_data, 0);
        chk("r32_rst_ready", d_in_ready, 0);
        @(negedge clk);
        d_rst_n = 1;
        @(negedge clk);
        chk("r32_ready_back", d_in_ready, 1);
        d_push(96'h1);
        d_drain(96'h80, 96'h1, "r32");

        // two-word variant: partial block discarded by reset, then both banks filled
        t_push(96'h9);
        #2 t_rst_n = 0;
        @(negedge clk);
        t_rst_n = 1;
        @(negedge clk);
        t_push(96'h1);
        t_push(96'h3);
        t_push(96'h5);
        t_push(96'h7);
        chk("t_full_ready0", t_in_ready, 0);
        chk("t_full_valid", t_out_valid, 1);
        @(negedge clk);
        chk("t_full_ready1", t_in_ready, 0);
        t_out_ready = 1;
        for (int b = 0; b < 6; b++) begin
            chk($sformatf("t_valid%0d", b), t_out_valid, 1);
            chk($sformatf("t_beat%0d", b), t_out_data, b == 0 ? 96'h1 : b == 3 ? 96'hd : '0);
`ifdef LDPC_SPARSE_MULT_LAST_EN
            chk($sformatf("t_last%0d", b), t_last, b == 2 || b == 5);
`endif
            if (b < 3) chk($sformatf("t_ready_held%0d", b), t_in_ready, 0);
            if (b == 3) chk("t_ready_after_drain", t_in_ready, 1);
            @(negedge clk);
        end
        chk("t_idle_valid", t_out_valid, 0);
        chk("t_idle_data", t_out_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied, %0d miscompares", n_vec, n_err + 1);
        $fatal(1);
    end
endmodule
